// File: rtl/imem_arbiter_pkg.sv
// Shared types and default widths for the instruction-memory arbiter slice.
package imem_arbiter_pkg;

  localparam int unsigned INSTR_MEM_ADDR_WIDTH = 32;
  localparam int unsigned INSTR_MEM_WIDTH      = 32;
  localparam int unsigned INSTR_MEM_TAG_WIDTH  = 32;

  typedef enum logic {PRIO_IFU, PRIO_AUX} arb_state_e;
  typedef enum logic {SRC_IFU, SRC_AUX}   src_e;

  typedef struct packed {
    src_e src;
    logic kill;
  } outst_entry_t;

  localparam int unsigned OUTST_ENTRY_W = $bits(outst_entry_t);
  localparam int unsigned KILL_BIT      = 0;

endpackage

// File: rtl/imem_arbiter_src_fifo.sv
// In-order FIFO of outstanding request sources, with a per-slot sticky kill bit.
module imem_arbiter_src_fifo #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned WIDTH    = 2,
  parameter int unsigned KILL_BIT = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic [DEPTH-1:0]         kill_set,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [AW-1:0]               wr_ptr;
  logic [AW-1:0]               rd_ptr;
  logic [AW:0]                 cnt;
  logic                        push_ok;
  logic                        pop_ok;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign head    = mem_q[rd_ptr];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      // Kill marks may land on free slots; a later push overwrites them.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (kill_set[i]) mem_q[i][KILL_BIT] <= 1'b1;
      end
      if (push_ok) begin
        mem_q[wr_ptr] <= push_data;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Shares the instruction-memory port between IFU fetch and the aux port;
// routes in-order responses back to their issuer and drops flushed fetches.
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_OUTST    = 4,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned ADDR_W       = INSTR_MEM_ADDR_WIDTH,
  parameter int unsigned DATA_W       = INSTR_MEM_WIDTH,
  parameter int unsigned TAG_W        = INSTR_MEM_TAG_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [ADDR_W-1:0] ifu_addr,
  input  logic              ifu_addr_valid,
  input  logic [TAG_W-1:0]  ifu_tag,
  output logic              ifu_gnt,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic              ifu_rdata_valid,
  output logic [TAG_W-1:0]  ifu_tag_rsp,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic              aux_gnt,
  output logic [DATA_W-1:0] aux_rdata,
  output logic              aux_rdata_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [TAG_W-1:0]  mem_tag_out,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdata_valid,
  input  logic [TAG_W-1:0]  mem_tag_in
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT) + 1;
  localparam int unsigned FW = $clog2(MAX_OUTST) + 1;
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT - 1);

  arb_state_e    state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          fifo_full, fifo_empty;
  logic [FW-1:0] fifo_count;
  logic          ifu_ok, aux_ok, push, pop;
  outst_entry_t  head, push_entry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= PRIO_IFU;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Grants are gated by rst_n so every output reads 0 while reset is held.
  always_comb begin
    ifu_ok   = rst_n & ifu_addr_valid & ~flush & ~fifo_full;
    aux_ok   = rst_n & aux_req & (aux_we | ~fifo_full);
    ifu_gnt  = 1'b0;
    aux_gnt  = 1'b0;
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      PRIO_IFU: begin
        ifu_gnt = ifu_ok;
        aux_gnt = aux_ok & ~ifu_ok;
        if (aux_req & ~aux_gnt) begin
          starve_d = starve_q + 1'b1;
          if (starve_d == STARVE_MAX) state_d = PRIO_AUX;
        end else begin
          starve_d = '0;
        end
      end
      PRIO_AUX: begin
        aux_gnt = aux_ok;
        ifu_gnt = ifu_ok & ~aux_ok;
        if (aux_gnt | ~aux_req) begin
          state_d  = PRIO_IFU;
          starve_d = '0;
        end
      end
      default: state_d = PRIO_IFU;
    endcase
  end

  always_comb begin
    push_entry      = '0;
    push_entry.src  = ifu_gnt ? SRC_IFU : SRC_AUX;
    push_entry.kill = 1'b0;
  end

  assign push = ifu_gnt | (aux_gnt & ~aux_we);
  assign pop  = mem_rdata_valid & ~fifo_empty;

  // Aux responses ignore kill, so flush can mark every slot unconditionally.
  imem_arbiter_src_fifo #(
    .DEPTH    (MAX_OUTST),
    .WIDTH    (OUTST_ENTRY_W),
    .KILL_BIT (KILL_BIT)
  ) u_src_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .kill_set  ({MAX_OUTST{flush}}),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign mem_valid   = ifu_gnt | aux_gnt;
  assign mem_we      = aux_gnt & aux_we;
  assign mem_addr    = ifu_gnt ? ifu_addr : (aux_gnt ? aux_addr : '0);
  assign mem_wdata   = mem_we ? aux_wdata : '0;
  assign mem_tag_out = ifu_gnt ? ifu_tag : '0;

  assign ifu_rdata_valid = pop & (head.src == SRC_IFU) & ~head.kill & ~flush;
  assign aux_rdata_valid = pop & (head.src == SRC_AUX);
  assign ifu_tag_rsp     = ifu_rdata_valid ? mem_tag_in : '0;
  assign ifu_rdata       = rst_n ? mem_rdata : '0;
  assign aux_rdata       = rst_n ? mem_rdata : '0;

  a_rsp_needs_entry: assert property (@(posedge clk) disable iff (!rst_n)
    mem_rdata_valid |-> !fifo_empty);

  a_count_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    fifo_count <= FW'(MAX_OUTST));

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: vector table, directed sequences and
// randomized traffic against a queue-based reference model and memory stub.
module tb_imem_arbiter;
  localparam int unsigned AW = 32, DW = 32, TW = 32, MAXO = 4, SL = 8;

  logic clk = 1'b0, rst_n = 1'b0, flush;
  logic [AW-1:0] ifu_addr, aux_addr, mem_addr;
  logic [TW-1:0] ifu_tag, ifu_tag_rsp, mem_tag_out, mem_tag_in;
  logic [DW-1:0] ifu_rdata, aux_rdata, aux_wdata, mem_wdata, mem_rdata;
  logic ifu_addr_valid, ifu_gnt, ifu_rdata_valid, aux_req, aux_we, aux_gnt;
  logic aux_rdata_valid, mem_valid, mem_we, mem_rdata_valid;

  always #5 clk = ~clk;

  imem_arbiter #(.MAX_OUTST(MAXO), .STARVE_LIMIT(SL), .ADDR_W(AW), .DATA_W(DW), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .ifu_addr(ifu_addr), .ifu_addr_valid(ifu_addr_valid), .ifu_tag(ifu_tag), .ifu_gnt(ifu_gnt),
    .ifu_rdata(ifu_rdata), .ifu_rdata_valid(ifu_rdata_valid), .ifu_tag_rsp(ifu_tag_rsp),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_gnt(aux_gnt), .aux_rdata(aux_rdata), .aux_rdata_valid(aux_rdata_valid),
    .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_tag_out(mem_tag_out), .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
    .mem_tag_in(mem_tag_in)
  );

  int n_vec = 0, n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory stub (driven by DUT requests) and reference model state.
  typedef struct { logic [31:0] data; logic [31:0] tag; int due; } rsp_t;
  typedef struct { bit aux; bit killed; logic [31:0] data; logic [31:0] tag; } ent_t;
  logic [31:0] env_mem [256];
  logic [31:0] ref_mem [256];
  rsp_t pend[$];
  ent_t outq[$];
  int   streak = 0, cyc = 0, lat_min = 2, lat_max = 2;
  bit   aux_turn = 0, mem_hold = 0;
  bit   obs_ifu_gnt, obs_aux_gnt;
  logic [31:0] rsp_tags[$];
  int   route[$];
  int   aux_rv_count = 0;
  logic [31:0] last_aux_data;

  function automatic logic [31:0] init_word(input int unsigned i);
    return 32'hC0DE_0000 | (i * 4);
  endfunction

  task automatic idle();
    flush = 0; ifu_addr_valid = 0; ifu_addr = '0; ifu_tag = '0;
    aux_req = 0; aux_we = 0; aux_addr = '0; aux_wdata = '0;
    mem_rdata_valid = 0; mem_rdata = '0; mem_tag_in = '0;
  endtask

  task automatic chk_all_zero(input string p);
    chk({p, "_ifu_gnt"}, ifu_gnt, 0);            chk({p, "_aux_gnt"}, aux_gnt, 0);
    chk({p, "_mem_valid"}, mem_valid, 0);        chk({p, "_mem_we"}, mem_we, 0);
    chk({p, "_mem_addr"}, mem_addr, 0);          chk({p, "_mem_wdata"}, mem_wdata, 0);
    chk({p, "_mem_tag_out"}, mem_tag_out, 0);    chk({p, "_ifu_rdata"}, ifu_rdata, 0);
    chk({p, "_ifu_rdata_valid"}, ifu_rdata_valid, 0);
    chk({p, "_ifu_tag_rsp"}, ifu_tag_rsp, 0);    chk({p, "_aux_rdata"}, aux_rdata, 0);
    chk({p, "_aux_rdata_valid"}, aux_rdata_valid, 0);
  endtask

  // One clock cycle; entered and left at posedge+1 with DUT inputs already set.
  task automatic cycle();
    bit rv, full, ifu_ok, aux_ok, e_ifu, e_aux, e_ifu_rv, e_aux_rv;
    logic [31:0] e_data, e_tag;
    int due;
    rv = !mem_hold && pend.size() > 0 && pend[0].due <= cyc;
    mem_rdata_valid = rv;
    if (rv) begin mem_rdata = pend[0].data; mem_tag_in = pend[0].tag; end
    else    begin mem_rdata = $urandom;     mem_tag_in = $urandom;    end
    #3;
    full   = outq.size() >= MAXO;
    ifu_ok = ifu_addr_valid && !flush && !full;
    aux_ok = aux_req && (aux_we || !full);
    if (aux_turn) begin e_aux = aux_ok; e_ifu = ifu_ok && !aux_ok; end
    else          begin e_ifu = ifu_ok; e_aux = aux_ok && !ifu_ok; end
    e_ifu_rv = 0; e_aux_rv = 0; e_data = mem_rdata; e_tag = '0;
    if (rv && outq.size() > 0) begin
      e_aux_rv = outq[0].aux;
      e_ifu_rv = !outq[0].aux && !outq[0].killed && !flush;
      e_data   = outq[0].data;
      if (e_ifu_rv) e_tag = outq[0].tag;
    end
    obs_ifu_gnt = ifu_gnt; obs_aux_gnt = aux_gnt;
    chk("ifu_gnt", ifu_gnt, e_ifu);
    chk("aux_gnt", aux_gnt, e_aux);
    chk("mem_valid", mem_valid, e_ifu | e_aux);
    chk("mem_we", mem_we, e_aux && aux_we);
    chk("mem_addr", mem_addr, e_ifu ? ifu_addr : (e_aux ? aux_addr : 32'h0));
    chk("mem_tag_out", mem_tag_out, e_ifu ? ifu_tag : 32'h0);
    chk("mem_wdata", mem_wdata, (e_aux && aux_we) ? aux_wdata : 32'h0);
    chk("ifu_rdata_valid", ifu_rdata_valid, e_ifu_rv);
    chk("aux_rdata_valid", aux_rdata_valid, e_aux_rv);
    chk("ifu_tag_rsp", ifu_tag_rsp, e_tag);
    chk("ifu_rdata", ifu_rdata, e_data);
    chk("aux_rdata", aux_rdata, e_data);
    if (ifu_rdata_valid) begin rsp_tags.push_back(ifu_tag_rsp); route.push_back(1); end
    if (aux_rdata_valid) begin route.push_back(2); aux_rv_count++; last_aux_data = aux_rdata; end
    // memory stub follows what the DUT actually issued
    if (rv) void'(pend.pop_front());
    if (mem_valid && mem_we) env_mem[mem_addr[9:2]] = mem_wdata;
    else if (mem_valid) begin
      due = cyc + $urandom_range(lat_max, lat_min);
      if (pend.size() > 0 && pend[pend.size()-1].due > due) due = pend[pend.size()-1].due;
      pend.push_back('{env_mem[mem_addr[9:2]], mem_tag_out, due});
    end
    // reference model follows the rules
    if (rv && outq.size() > 0) void'(outq.pop_front());
    if (flush) foreach (outq[i]) if (!outq[i].aux) outq[i].killed = 1;
    if (e_ifu) outq.push_back('{0, 0, ref_mem[ifu_addr[9:2]], ifu_tag});
    else if (e_aux && !aux_we) outq.push_back('{1, 0, ref_mem[aux_addr[9:2]], 32'h0});
    else if (e_aux) ref_mem[aux_addr[9:2]] = aux_wdata;
    if (e_aux || !aux_req) begin streak = 0; aux_turn = 0; end
    else if (!aux_turn) begin streak++; if (streak == SL - 1) aux_turn = 1; end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic drain();
    int k;
    idle(); mem_hold = 0; k = 0;
    while ((outq.size() > 0 || pend.size() > 0) && k < 40) begin cycle(); k++; end
    chk("drain_outq_empty", outq.size(), 0);
  endtask

  typedef struct { bit ifu_v, aux_r, aux_w, fl, e_ig, e_ag, e_mv, e_we; } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    int first, cnt;
    tbl[0] = '{0,0,0,0, 0,0,0,0};
    tbl[1] = '{1,0,0,0, 1,0,1,0};
    tbl[2] = '{0,1,0,0, 0,1,1,0};
    tbl[3] = '{0,1,1,0, 0,1,1,1};
    tbl[4] = '{1,1,0,0, 1,0,1,0};
    tbl[5] = '{1,0,0,1, 0,0,0,0};
    tbl[6] = '{1,1,1,1, 0,1,1,1};
    tbl[7] = '{1,1,0,1, 0,1,1,0};
    for (int unsigned i = 0; i < 256; i++) begin env_mem[i] = init_word(i); ref_mem[i] = init_word(i); end

    // reset: outputs forced to 0 despite active inputs
    idle();
    ifu_addr_valid = 1; ifu_addr = 32'h44; ifu_tag = 32'h44; aux_req = 1; aux_we = 1;
    aux_addr = 32'h48; aux_wdata = 32'h1111; mem_rdata_valid = 1; mem_rdata = 32'hDEADBEEF;
    mem_tag_in = 32'h1234;
    #12; chk_all_zero("reset");
    idle(); @(negedge clk); rst_n = 1; @(posedge clk); #1;

    // combinational grant table, inputs idle across each clock edge
    for (int i = 0; i < 8; i++) begin
      ifu_addr_valid = tbl[i].ifu_v; aux_req = tbl[i].aux_r; aux_we = tbl[i].aux_w;
      flush = tbl[i].fl; ifu_addr = 32'h200 + i * 4; aux_addr = 32'h300 + i * 4;
      #2;
      chk("tbl_ifu_gnt", ifu_gnt, tbl[i].e_ig);  chk("tbl_aux_gnt", aux_gnt, tbl[i].e_ag);
      chk("tbl_mem_valid", mem_valid, tbl[i].e_mv); chk("tbl_mem_we", mem_we, tbl[i].e_we);
      idle(); @(posedge clk); #1;
    end

    // IFU-only reads, latency 2
    rsp_tags.delete(); aux_rv_count = 0;
    for (int i = 0; i < 3; i++) begin
      idle(); ifu_addr_valid = 1; ifu_addr = i * 4; ifu_tag = i * 4;
      cycle(); chk("ifuonly_gnt", obs_ifu_gnt, 1);
    end
    idle(); repeat (4) cycle();
    chk("ifuonly_nrsp", rsp_tags.size(), 3);
    for (int k = 0; k < 3; k++) if (rsp_tags.size() > k) chk("ifuonly_tag", rsp_tags[k], k * 4);
    chk("ifuonly_aux_rv", aux_rv_count, 0);

    // FIFO fill with responses held off; aux write still accepted when full
    mem_hold = 1; cnt = 0;
    for (int i = 0; i < 6; i++) begin
      idle(); ifu_addr_valid = 1; ifu_addr = 32'h60 + i * 4; ifu_tag = 32'h60 + i * 4;
      cycle(); cnt += obs_ifu_gnt;
    end
    chk("fill_grants", cnt, 4);
    chk("fill_blocked", obs_ifu_gnt, 0);
    aux_req = 1; aux_we = 1; aux_addr = 32'h80; aux_wdata = 32'hA5A5_0080;
    cycle(); chk("fill_aux_write", obs_aux_gnt, 1); chk("fill_ifu_held", obs_ifu_gnt, 0);
    aux_req = 0; aux_we = 0; mem_hold = 0; first = -1;
    for (int k = 0; k < 10 && first < 0; k++) begin cycle(); if (obs_ifu_gnt) first = k; end
    chk("fill_resume", first, 1);
    drain();

    // starvation: aux read wins in its 8th requesting cycle
    aux_rv_count = 0; first = 0;
    ifu_addr_valid = 1; aux_req = 1; aux_we = 0; aux_addr = 32'h40;
    for (int k = 1; k <= 12 && first == 0; k++) begin
      ifu_addr = 32'h100 + k * 4; ifu_tag = ifu_addr;
      cycle(); if (obs_aux_gnt) first = k;
    end
    chk("starve_cycle", first, SL);
    aux_req = 0; cycle(); chk("starve_ifu_resume", obs_ifu_gnt, 1);
    drain();
    chk("starve_aux_rsp", aux_rv_count, 1);
    chk("starve_aux_data", last_aux_data, init_word(16));

    // flush: 3 reads pending, flush coincides with the first pop, then fetch 0x100
    mem_hold = 1;
    for (int i = 0; i < 3; i++) begin
      idle(); ifu_addr_valid = 1; ifu_addr = 32'h30 + i * 4; ifu_tag = 32'h30 + i * 4; cycle();
    end
    idle(); rsp_tags.delete(); mem_hold = 0; flush = 1; cycle();
    idle(); ifu_addr_valid = 1; ifu_addr = 32'h100; ifu_tag = 32'h100; cycle();
    chk("flush_new_gnt", obs_ifu_gnt, 1);
    drain();
    chk("flush_nrsp", rsp_tags.size(), 1);
    if (rsp_tags.size() > 0) chk("flush_tag", rsp_tags[0], 32'h100);

    // mixed sources routed in request order
    route.delete();
    idle(); ifu_addr_valid = 1; ifu_addr = 32'h10; ifu_tag = 32'h10; cycle();
    idle(); aux_req = 1; aux_addr = 32'h20; cycle();
    idle(); ifu_addr_valid = 1; ifu_addr = 32'h14; ifu_tag = 32'h14; cycle();
    drain();
    chk("mixed_nrsp", route.size(), 3);
    for (int k = 0; k < 3; k++) if (route.size() > k) chk("mixed_route", route[k], (k == 1) ? 2 : 1);

    // reset with two reads outstanding
    mem_hold = 1;
    for (int i = 0; i < 2; i++) begin
      idle(); ifu_addr_valid = 1; ifu_addr = 32'h50 + i * 4; ifu_tag = 32'h50 + i * 4; cycle();
    end
    ifu_addr = 32'h58; aux_req = 1; aux_we = 1; aux_addr = 32'h5C; aux_wdata = 32'h77;
    mem_rdata_valid = 1; mem_rdata = 32'h1234_5678; mem_tag_in = 32'h50;
    rst_n = 0; #1;
    chk_all_zero("midreset");
    idle(); @(negedge clk); rst_n = 1;
    pend.delete(); outq.delete(); streak = 0; aux_turn = 0;
    @(posedge clk); #1;
    idle(); ifu_addr_valid = 1; ifu_addr = 32'h90; ifu_tag = 32'h90; aux_req = 1; aux_addr = 32'h94;
    cycle(); chk("postrst_ifu_prio", obs_ifu_gnt, 1);
    aux_req = 0; cnt = 1;
    for (int i = 0; i < 4; i++) begin ifu_addr = 32'hA0 + i * 4; ifu_tag = ifu_addr; cycle(); cnt += obs_ifu_gnt; end
    chk("postrst_fifo_empty", cnt, 4);
    drain();

    // randomized traffic
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 400; i++) begin
      ifu_addr_valid = ($urandom_range(0, 3) != 0);
      ifu_addr = 32'($urandom_range(0, 255)) << 2; ifu_tag = $urandom;
      aux_req = ($urandom_range(0, 2) == 0); aux_we = $urandom_range(0, 1);
      aux_addr = 32'($urandom_range(0, 255)) << 2; aux_wdata = $urandom;
      flush = ($urandom_range(0, 19) == 0); mem_hold = ($urandom_range(0, 3) == 0);
      cycle();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single instruction-memory port between two requesters: the IFU fetch path and an auxiliary read/write port (program loader / debug).
- Sits between ifu and the instruction memory. Grants one request per cycle and tracks outstanding requests in an in-order source FIFO.
- Routes each memory response back to the requester that issued it.
- Discards IFU responses that were in flight when a pipeline redirect (flush) occurred.

Parameters:
- MAX_OUTST, 4, maximum outstanding memory requests; power of 2, at least 2.
- STARVE_LIMIT, 8, consecutive cycles aux may be denied before it is forced to win.
- ADDR_W, INSTR_MEM_ADDR_WIDTH, memory address width.
- DATA_W, INSTR_MEM_WIDTH, memory data width.
- TAG_W, INSTR_MEM_TAG_WIDTH, memory tag width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  pipeline redirect (pc_load); kills in-flight IFU responses
- ifu_addr  in  ADDR_W  fetch address
- ifu_addr_valid  in  1  fetch request
- ifu_tag  in  TAG_W  fetch tag (PC)
- ifu_gnt  out  1  fetch accepted this cycle; IFU stalls while it is low
- ifu_rdata  out  DATA_W  fetch response data
- ifu_rdata_valid  out  1  fetch response valid
- ifu_tag_rsp  out  TAG_W  fetch response tag
- aux_req  in  1  aux request
- aux_we  in  1  1 = write, 0 = read
- aux_addr  in  ADDR_W  aux address
- aux_wdata  in  DATA_W  aux write data
- aux_gnt  out  1  aux accepted this cycle
- aux_rdata  out  DATA_W  aux read data
- aux_rdata_valid  out  1  aux read response valid
- mem_addr  out  ADDR_W  memory address
- mem_valid  out  1  memory request
- mem_we  out  1  memory write enable
- mem_wdata  out  DATA_W  memory write data
- mem_tag_out  out  TAG_W  memory tag out
- mem_rdata  in  DATA_W  memory read data
- mem_rdata_valid  in  1  memory response valid; responses always return in request order
- mem_tag_in  in  TAG_W  memory response tag

Behaviour:
- Reset (async, rst_n low):
  - FSM goes to PRIO_IFU; source FIFO empty; starve counter 0.
  - All outputs 0.
- Request/grant path:
  - The request mux is combinational; grants are issued in the same cycle as the request.
  - mem_valid = ifu_gnt | aux_gnt; at most one grant per cycle.
  - mem_we = aux_gnt & aux_we; mem_tag_out = ifu_tag for IFU grants, 0 for aux grants.
- Write handling: writes get no response and consume no FIFO entry.
- Grant suppression:
  - No read grant while FIFO is full.
  - Writes may still be granted when the FIFO is full.
  - No IFU grant in a cycle with flush = 1.
- FSM PRIO_IFU:
  - IFU wins when both request.
  - Starve counter increments each cycle aux_req = 1 and aux_gnt = 0; it clears on aux_gnt or when aux_req = 0.
  - Counter reaching STARVE_LIMIT-1 moves the FSM to PRIO_AUX.
- FSM PRIO_AUX:
  - aux wins the next eligible cycle.
  - On aux_gnt, or if aux_req drops, return to PRIO_IFU and clear the counter.
- Source FIFO:
  - Each granted read pushes {src, kill = 0}.
  - mem_rdata_valid pops the head entry.
  - Push and pop in the same cycle are legal; count is unchanged.
- Response routing (combinational from the memory response and FIFO head, zero added latency):
  - src = AUX: aux_rdata_valid = 1.
  - src = IFU and kill = 0: ifu_rdata_valid = 1, ifu_tag_rsp = mem_tag_in.
  - src = IFU and kill = 1: response dropped silently.
  - Data buses always mirror mem_rdata.
- flush:
  - Sets kill on every IFU entry currently in the FIFO.
  - An entry popped in the same cycle is also killed.
  - Aux entries are unaffected.
- mem_rdata_valid with an empty FIFO is a protocol error: the response is ignored; SVA assertion fires.
- Reset mid-operation:
  - FIFO is cleared, so responses still in flight become orphaned.
  - The system resets the memory together with this block.

Decomposition:
- Add to the shared package (global.svh):
  - typedef arb_state_e {PRIO_IFU, PRIO_AUX}.
  - typedef src_e {SRC_IFU, SRC_AUX}.
  - Struct outst_entry_t {src_e src; logic kill}.
- One sub-module: src_fifo.
  - Parameterised depth/width, async reset.
  - Push, pop, full, empty, count.
  - Per-entry kill-set input for flush.

Test Plan:
- IFU-only reads to 0x00, 0x04, 0x08, memory latency 2 → ifu_gnt = 1 each cycle; 3 ifu_rdata_valid with tags 0x00/0x04/0x08 in order; aux outputs stay 0.
- FIFO fill: IFU streams with memory responses held off → 4 grants, then ifu_gnt = 0 until the first response; aux write still granted while full.
- Starvation: IFU requests continuously plus aux read at 0x40 → aux_gnt asserted exactly in cycle 8 of aux_req; aux_rdata_valid returns data for 0x40; IFU resumes next cycle.
- Flush: 3 IFU reads outstanding, flush pulsed, then a new fetch at 0x100 → first 3 responses dropped, only the 0x100 response reaches IFU.
- Mixed order: issue IFU 0x10, aux 0x20, IFU 0x14 → responses routed IFU, aux, IFU respectively.
- Reset mid-operation: rst_n low with 2 reads outstanding → all outputs 0 immediately; FIFO empty; FSM in PRIO_IFU after release.
